// File: rtl/reflet_mem_arbiter.sv
// Reflet RAM port arbiter: CPU owns the port, a secondary master borrows it
// at instruction boundaries, with one CPU instruction forced between tenures.
module reflet_mem_arbiter #(
  parameter int wordsize  = 16,
  parameter int max_burst = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_data_out,
  input  logic                cpu_write_en,
  input  logic                cpu_ram_not_ready,
  output logic [wordsize-1:0] cpu_data_in,
  output logic                cpu_enable,
  input  logic                dev_req,
  input  logic [wordsize-1:0] dev_addr,
  input  logic [wordsize-1:0] dev_data_out,
  input  logic                dev_write_en,
  output logic [wordsize-1:0] dev_data_in,
  output logic                dev_ack,
  output logic                dev_grant,
  output logic [wordsize-1:0] ram_addr,
  output logic [wordsize-1:0] ram_data_out,
  input  logic [wordsize-1:0] ram_data_in,
  output logic                ram_write_en
);

  localparam int CW = $clog2(max_burst + 1);
  localparam logic [CW-1:0] LAST = CW'(max_burst - 1);

  typedef enum logic [1:0] {
    S_CPU,
    S_DEV_ADDR,
    S_DEV_DATA
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] burst_cnt, burst_nxt;
  logic          cpu_owed, owed_nxt;
  logic          grant_now;
  logic          mux_we;

  // Reset gating keeps the CPU running and the RAM untouched while held.
  assign grant_now = reset && (state == S_CPU) && dev_req &&
                     !cpu_ram_not_ready && !cpu_owed;

  assign cpu_enable   = (state == S_CPU) && !grant_now;
  assign dev_grant    = (state != S_CPU);
  assign cpu_data_in  = ram_data_in;
  assign dev_data_in  = ram_data_in;
  assign ram_write_en = reset && mux_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_CPU;
      burst_cnt <= '0;
      cpu_owed  <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      cpu_owed  <= owed_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    burst_nxt    = burst_cnt;
    owed_nxt     = cpu_owed;
    ram_addr     = cpu_addr;
    ram_data_out = cpu_data_out;
    mux_we       = cpu_write_en;
    dev_ack      = 1'b0;
    unique case (state)
      S_CPU: begin
        if (cpu_ram_not_ready) owed_nxt = 1'b0;
        if (grant_now) begin
          state_nxt = S_DEV_ADDR;
          burst_nxt = '0;
        end
      end
      S_DEV_ADDR: begin
        ram_addr     = dev_addr;
        ram_data_out = dev_data_out;
        mux_we       = dev_write_en;
        state_nxt    = S_DEV_DATA;
      end
      S_DEV_DATA: begin
        ram_addr     = dev_addr;
        ram_data_out = dev_data_out;
        mux_we       = 1'b0;
        dev_ack      = 1'b1;
        burst_nxt    = burst_cnt + CW'(1);
        if (dev_req && burst_cnt < LAST) begin
          state_nxt = S_DEV_ADDR;
        end else begin
          state_nxt = S_CPU;
          owed_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_CPU;
    endcase
  end

endmodule

// File: tb/tb_reflet_mem_arbiter.sv
// Directed vector bench for reflet_mem_arbiter with a 1-cycle RAM model.
module tb_reflet_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr, cpu_data_out, cpu_data_in;
  logic        cpu_write_en, cpu_ram_not_ready, cpu_enable;
  logic        dev_req, dev_write_en, dev_ack, dev_grant;
  logic [15:0] dev_addr, dev_data_out, dev_data_in;
  logic [15:0] ram_addr, ram_data_out;
  logic [15:0] ram_data_in = 16'h0000;
  logic        ram_write_en;
  logic [15:0] mem [256];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reflet_mem_arbiter #(.wordsize(16), .max_burst(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_write_en(cpu_write_en),
    .cpu_ram_not_ready(cpu_ram_not_ready),
    .cpu_data_in(cpu_data_in), .cpu_enable(cpu_enable),
    .dev_req(dev_req), .dev_addr(dev_addr),
    .dev_data_out(dev_data_out), .dev_write_en(dev_write_en),
    .dev_data_in(dev_data_in), .dev_ack(dev_ack),
    .dev_grant(dev_grant), .ram_addr(ram_addr),
    .ram_data_out(ram_data_out), .ram_data_in(ram_data_in),
    .ram_write_en(ram_write_en)
  );

  always @(posedge clk) begin
    if (ram_write_en) mem[ram_addr[7:0]] <= ram_data_out;
    ram_data_in <= mem[ram_addr[7:0]];
  end

  typedef struct {
    logic        dreq, rnr, dwe;
    logic [15:0] daddr, ddat, caddr;
    logic        cwe;
    logic        en, gnt, ack;
    logic [15:0] raddr;
    logic        rwe;
    int          chk;
    logic [15:0] din;
  } vec_t;

  vec_t tbl [35];

  function automatic vec_t mk(
    logic dreq, logic rnr, logic dwe,
    logic [15:0] daddr, logic [15:0] ddat,
    logic [15:0] caddr, logic cwe,
    logic en, logic gnt, logic ack,
    logic [15:0] raddr, logic rwe,
    int chk, logic [15:0] din);
    vec_t v;
    v.dreq = dreq; v.rnr = rnr; v.dwe = dwe;
    v.daddr = daddr; v.ddat = ddat;
    v.caddr = caddr; v.cwe = cwe;
    v.en = en; v.gnt = gnt; v.ack = ack;
    v.raddr = raddr; v.rwe = rwe;
    v.chk = chk; v.din = din;
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(0,1,0,0,0,'h05,0, 1,0,0,'h05,0,0,0);
    tbl[1]  = mk(0,1,0,0,0,'h06,1, 1,0,0,'h06,1,0,0);
    tbl[2]  = mk(0,0,0,0,0,'h07,0, 1,0,0,'h07,0,0,0);
    tbl[3]  = mk(1,1,0,'h40,0,'h08,0, 1,0,0,'h08,0,0,0);
    tbl[4]  = mk(1,0,0,'h40,0,'h09,0, 0,0,0,'h09,0,0,0);
    tbl[5]  = mk(1,0,0,'h40,0,'h09,0, 0,1,0,'h40,0,0,0);
    tbl[6]  = mk(0,0,0,'h40,0,'h09,0, 0,1,1,'h40,0,1,'hBEEF);
    tbl[7]  = mk(0,0,0,'h40,0,'h09,0, 1,0,0,'h09,0,0,0);
    tbl[8]  = mk(1,1,1,'h10,'h1234,'h0A,0, 1,0,0,'h0A,0,0,0);
    tbl[9]  = mk(1,0,1,'h10,'h1234,'h0B,0, 0,0,0,'h0B,0,0,0);
    tbl[10] = mk(1,0,1,'h10,'h1234,'h0B,0, 0,1,0,'h10,1,0,0);
    tbl[11] = mk(0,0,1,'h10,'h1234,'h0B,0, 0,1,1,'h10,0,0,0);
    tbl[12] = mk(0,0,0,0,0,'h0C,0, 1,0,0,'h0C,0,0,0);
    tbl[13] = mk(0,1,0,0,0,'h10,0, 1,0,0,'h10,0,0,0);
    tbl[14] = mk(0,1,0,0,0,'h11,0, 1,0,0,'h11,0,2,'h1234);
    tbl[15] = mk(1,1,0,'h40,0,'h12,0, 1,0,0,'h12,0,0,0);
    tbl[16] = mk(1,0,0,'h40,0,'h13,0, 0,0,0,'h13,0,0,0);
    tbl[17] = mk(1,0,0,'h40,0,'h13,0, 0,1,0,'h40,0,0,0);
    tbl[18] = mk(1,0,0,'h40,0,'h13,0, 0,1,1,'h40,0,1,'hBEEF);
    tbl[19] = mk(1,0,0,'h06,0,'h13,0, 0,1,0,'h06,0,0,0);
    tbl[20] = mk(1,0,0,'h06,0,'h13,0, 0,1,1,'h06,0,1,'h5555);
    tbl[21] = mk(1,0,0,'h10,0,'h13,0, 0,1,0,'h10,0,0,0);
    tbl[22] = mk(1,0,0,'h10,0,'h13,0, 0,1,1,'h10,0,1,'h1234);
    tbl[23] = mk(1,0,0,'h40,0,'h13,0, 0,1,0,'h40,0,0,0);
    tbl[24] = mk(1,0,0,'h40,0,'h13,0, 0,1,1,'h40,0,1,'hBEEF);
    tbl[25] = mk(1,0,0,'h40,0,'h13,0, 1,0,0,'h13,0,0,0);
    tbl[26] = mk(1,0,0,'h40,0,'h13,0, 1,0,0,'h13,0,0,0);
    tbl[27] = mk(1,1,0,'h40,0,'h14,0, 1,0,0,'h14,0,0,0);
    tbl[28] = mk(1,0,0,'h40,0,'h15,0, 0,0,0,'h15,0,0,0);
    tbl[29] = mk(0,0,0,'h40,0,'h15,0, 0,1,0,'h40,0,0,0);
    tbl[30] = mk(0,0,0,'h40,0,'h15,0, 0,1,1,'h40,0,1,'hBEEF);
    tbl[31] = mk(0,0,0,0,0,'h15,0, 1,0,0,'h15,0,0,0);
    tbl[32] = mk(1,1,0,'h40,0,'h16,0, 1,0,0,'h16,0,0,0);
    tbl[33] = mk(0,1,0,'h40,0,'h16,0, 1,0,0,'h16,0,0,0);
    tbl[34] = mk(0,0,0,'h40,0,'h17,0, 1,0,0,'h17,0,0,0);

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h40] = 16'hBEEF;

    // reset: request at a boundary and a CPU write strobe must both be masked
    reset = 1'b0;
    cpu_addr = 16'h0003; cpu_data_out = 16'h5555;
    cpu_write_en = 1'b1; cpu_ram_not_ready = 1'b0;
    dev_req = 1'b1; dev_addr = 16'h0040;
    dev_data_out = 16'h0000; dev_write_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_enable", 16'(cpu_enable), 16'd1);
    chk("rst_grant", 16'(dev_grant), 16'd0);
    chk("rst_ack", 16'(dev_ack), 16'd0);
    chk("rst_ram_we", 16'(ram_write_en), 16'd0);

    step();
    reset = 1'b1;
    dev_req = 1'b0; cpu_write_en = 1'b0;
    cpu_ram_not_ready = 1'b1;

    for (int i = 0; i < 35; i++) begin
      step();
      dev_req = tbl[i].dreq;
      cpu_ram_not_ready = tbl[i].rnr;
      dev_write_en = tbl[i].dwe;
      dev_addr = tbl[i].daddr;
      dev_data_out = tbl[i].ddat;
      cpu_addr = tbl[i].caddr;
      cpu_write_en = tbl[i].cwe;
      @(negedge clk);
      chk($sformatf("v%0d_enable", i), 16'(cpu_enable), 16'(tbl[i].en));
      chk($sformatf("v%0d_grant", i), 16'(dev_grant), 16'(tbl[i].gnt));
      chk($sformatf("v%0d_ack", i), 16'(dev_ack), 16'(tbl[i].ack));
      chk($sformatf("v%0d_ram_addr", i), ram_addr, tbl[i].raddr);
      chk($sformatf("v%0d_ram_we", i), 16'(ram_write_en), 16'(tbl[i].rwe));
      if (tbl[i].rwe)
        chk($sformatf("v%0d_ram_wdata", i), ram_data_out,
            tbl[i].gnt ? tbl[i].ddat : 16'h5555);
      if (tbl[i].chk == 1)
        chk($sformatf("v%0d_dev_data", i), dev_data_in, tbl[i].din);
      if (tbl[i].chk == 2)
        chk($sformatf("v%0d_cpu_data", i), cpu_data_in, tbl[i].din);
    end

    // reset in the address phase of a secondary write
    step();
    dev_req = 1'b0; cpu_ram_not_ready = 1'b1;
    cpu_addr = 16'h0018; cpu_write_en = 1'b0;
    step();
    dev_req = 1'b1; dev_write_en = 1'b1;
    dev_addr = 16'h0020; dev_data_out = 16'hAAAA;
    cpu_ram_not_ready = 1'b0;
    @(negedge clk);
    chk("rw_boundary_enable", 16'(cpu_enable), 16'd0);
    step();
    @(negedge clk);
    chk("rw_addr_grant", 16'(dev_grant), 16'd1);
    chk("rw_addr_we", 16'(ram_write_en), 16'd1);
    #1 reset = 1'b0;
    #1;
    chk("rw_abort_we", 16'(ram_write_en), 16'd0);
    chk("rw_abort_grant", 16'(dev_grant), 16'd0);
    chk("rw_abort_enable", 16'(cpu_enable), 16'd1);
    chk("rw_abort_ack", 16'(dev_ack), 16'd0);
    @(negedge clk);
    chk("rw_held_ack", 16'(dev_ack), 16'd0);
    chk("rw_held_enable", 16'(cpu_enable), 16'd1);
    chk("rw_no_write", mem[8'h20], 16'h0000);
    step();
    reset = 1'b1;
    dev_req = 1'b0; cpu_ram_not_ready = 1'b1;
    cpu_addr = 16'h0021; cpu_write_en = 1'b1;
    @(negedge clk);
    chk("post_rst_enable", 16'(cpu_enable), 16'd1);
    chk("post_rst_addr", ram_addr, 16'h0021);
    chk("post_rst_we", 16'(ram_write_en), 16'd1);
    chk("post_rst_wdata", ram_data_out, 16'h5555);
    step();
    cpu_write_en = 1'b0; cpu_ram_not_ready = 1'b0;
    dev_req = 1'b1; dev_write_en = 1'b0; dev_addr = 16'h0040;
    @(negedge clk);
    chk("post_rst_grant_enable", 16'(cpu_enable), 16'd0);
    step();
    @(negedge clk);
    chk("post_rst_grant", 16'(dev_grant), 16'd1);
    chk("post_rst_ram_addr", ram_addr, 16'h0040);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
